vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
- Receive-side counterpart of the team's VGA timing generator: consumes Hsync, Vsync and 12-bit RGB from a 640x480@60 source on the same clock and rebuilds pixel coordinates.
- Checks line and frame timing and reports lock.
- Emits one qualified pixel strobe per visible pixel.
- Used for loopback self-test of the display path and for frame-grab logic downstream.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_BACK, 48, back-porch pixels
- H_SYNC, 96, Hsync pulse width in pixels
- H_TOTAL, 800, pixels per line including blanking
- V_VISIBLE, 480, visible lines per frame
- V_BACK, 33, back-porch lines
- V_SYNC, 2, Vsync pulse width in lines
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive good frames required for lock

Ports:
- clk  in  1  system clock, 50 MHz; pixel rate is clk/2
- rst  in  1  synchronous active-high reset
- Hsync  in  1  horizontal sync, active low, synchronous to clk
- Vsync  in  1  vertical sync, active low, synchronous to clk
- RGB_in  in  12  pixel data {R[11:8],G[7:4],B[3:0]}
- pix_valid  out  1  one-clk strobe: PixX/PixY/RGB_out hold a visible pixel
- PixX  out  10  visible column 0..639
- PixY  out  10  visible row 0..479
- RGB_out  out  12  captured pixel data
- frame_start  out  1  one-clk strobe on each detected frame boundary
- locked  out  1  timing verified
- timing_err  out  1  one-clk strobe on any line/frame length mismatch or timeout

Behaviour:
Reset:
- All outputs 0.
- px_en = 0, hpos = 1023, vpos = 1023, good-frame count = 0.
- Previous Hsync/Vsync sample registers = 1.
- Reset mid-frame discards all state; a new lock is required.

Pixel enable:
- Internal px_en toggles every clk: first clk after reset release is 0, the next is 1.
- Inputs are sampled only on px_en=1 cycles ("ticks").

Horizontal:
- hfall on a tick when sampled Hsync=0 and the previous tick's sample was 1.
- hidx = hfall ? 0 : min(hpos+1, 1023); hpos <= hidx each tick.
- On hfall, the old hpos must equal H_TOTAL-1 (799); otherwise it is a line error.
- The first hfall after reset or timeout is exempt from the length check.

Vertical:
- A Vsync falling edge on a tick sets vpend.
- At the next hfall: vidx = 0 and vpend is cleared; otherwise each hfall sets vidx = min(vpos+1, 1023).
- A frame boundary with old vpos != V_TOTAL-1 (524) is a frame error; the first boundary after reset/timeout is exempt.
- frame_start pulses one clk after the tick that resets vidx.

Visible window:
- Horizontal: hidx in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE-1] = [144,783].
- Vertical: vpos in [V_SYNC+V_BACK, +V_VISIBLE-1] = [35,514].
- PixX = hidx-144, PixY = vpos-35.

Output timing:
- Latency: pix_valid, PixX, PixY and RGB_out are registered and update on the clk after the tick. pix_valid is high for exactly that one clk.
- pix_valid asserts only while locked=1.
- PixX/PixY/RGB_out hold their last value otherwise.

Lock FSM:
- States: SEARCH, VERIFY, LOCKED.
- SEARCH: go to VERIFY on the first frame boundary.
- VERIFY: each error-free frame increments the count; at LOCK_FRAMES, enter LOCKED. locked rises with the frame_start of that boundary.
- Any line/frame error or timeout, in any state: timing_err pulses, count = 0, locked = 0 on the next clk, state = SEARCH.
- Timeout: hpos reaching 1023 (no hfall for 1023 ticks) counts as an error once, then re-arms the exemptions.
- Simultaneous events: if a line error and a frame boundary occur on the same tick, the error wins and the frame does not count.

Arithmetic:
- All counters are 10-bit and saturate at 1023; no wrap-around.

Test Plan:
- Reset held 4 clks with toggling inputs -> all outputs 0, no pix_valid.
- Drive 3 nominal 800x525 frames from a reference timing generator -> locked=1 at the 3rd frame_start; 307200 pix_valid strobes in the next frame; first strobe PixX=0, PixY=0 with RGB of hidx 144, vpos 35; last strobe PixX=639, PixY=479.
- Loopback with RGB_in = {PixX[3:0],PixY[3:0],4'hA} -> every captured RGB_out matches the coordinates.
- Once locked, shorten one line to 799 pixels -> timing_err one clk, locked=0 next clk, relock after 3 more good boundaries (SEARCH, then 2 good frames).
- Hold Hsync high after lock -> timing_err once when hpos hits 1023, locked=0, no further pulses until activity resumes.
- Assert rst for 1 clk mid-visible-line while locked -> locked=0, pix_valid stays 0 until lock is reacquired.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: rebuilds pixel coordinates from 640x480@60 Hsync/Vsync/RGB, verifies timing and reports lock
// Ports: clk/rst (sync, active high); Hsync/Vsync active-low syncs and RGB_in, sampled every other clk;
// pix_valid/PixX/PixY/RGB_out one strobe per visible pixel while locked; frame_start per frame boundary;
// locked after LOCK_FRAMES good frames; timing_err strobe on line/frame length mismatch or sync timeout.
module vga_capture #(
    parameter int H_VISIBLE   = 640,
    parameter int H_BACK      = 48,
    parameter int H_SYNC      = 96,
    parameter int H_TOTAL     = 800,
    parameter int V_VISIBLE   = 480,
    parameter int V_BACK      = 33,
    parameter int V_SYNC      = 2,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Hsync,
    input  logic        Vsync,
    input  logic [11:0] RGB_in,
    output logic        pix_valid,
    output logic [9:0]  PixX,
    output logic [9:0]  PixY,
    output logic [11:0] RGB_out,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err
);
    localparam logic [9:0] MAX     = 10'h3ff;
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_0 = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_VIS_1 = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
    localparam logic [9:0] V_VIS_0 = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_VIS_1 = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);
    localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t      state_q, state_d;
    logic        px_en_q, px_en_d, hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic        vpend_q, vpend_d, hfirst_q, hfirst_d, vfirst_q, vfirst_d;
    logic [9:0]  hpos_q, hpos_d, vpos_q, vpos_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
    logic        locked_q, locked_d, timing_err_q, timing_err_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [11:0] rgb_q, rgb_d;
    logic        tick, hfall, vfall, boundary, line_err, frame_err, timeout, err, visible;
    logic [9:0]  hinc, vinc, hidx, vidx;

    always_comb begin
        tick      = px_en_q;
        hfall     = tick && !Hsync && hs_prev_q;
        vfall     = tick && !Vsync && vs_prev_q;
        // a Vsync fall on the same tick as the Hsync fall starts the frame on this line
        boundary  = hfall && (vpend_q || vfall);
        hinc      = (hpos_q == MAX) ? MAX : hpos_q + 10'd1;
        vinc      = (vpos_q == MAX) ? MAX : vpos_q + 10'd1;
        hidx      = hfall ? '0 : hinc;
        vidx      = boundary ? '0 : (hfall ? vinc : vpos_q);
        line_err  = hfall && !hfirst_q && (hpos_q != H_LAST);
        frame_err = boundary && !vfirst_q && (vpos_q != V_LAST);
        // fires only on the step into saturation, so a dead link reports once
        timeout   = tick && (hidx == MAX) && (hpos_q != MAX);
        err       = line_err || frame_err || timeout;
        visible   = tick && (hidx >= H_VIS_0) && (hidx <= H_VIS_1) && (vidx >= V_VIS_0) && (vidx <= V_VIS_1);
        px_en_d       = !px_en_q;
        hs_prev_d     = tick ? Hsync : hs_prev_q;
        vs_prev_d     = tick ? Vsync : vs_prev_q;
        hpos_d        = tick ? hidx : hpos_q;
        vpos_d        = tick ? vidx : vpos_q;
        vpend_d       = boundary ? 1'b0 : (vfall || vpend_q);
        hfirst_d      = timeout || (hfirst_q && !hfall);
        vfirst_d      = timeout || (vfirst_q && !boundary);
        pix_valid_d   = visible && locked_q;
        pix_x_d       = pix_valid_d ? hidx - H_VIS_0 : pix_x_q;
        pix_y_d       = pix_valid_d ? vidx - V_VIS_0 : pix_y_q;
        rgb_d         = pix_valid_d ? RGB_in : rgb_q;
        frame_start_d = boundary;
        timing_err_d  = err;
        state_d       = state_q;
        cnt_d         = cnt_q;
        locked_d      = locked_q;
        if (err) begin
            state_d  = SEARCH;
            cnt_d    = '0;
            locked_d = 1'b0;
        end else if (boundary && state_q == SEARCH) begin
            state_d = VERIFY;
        end else if (boundary && state_q == VERIFY) begin
            cnt_d    = cnt_q + 4'd1;
            state_d  = (cnt_q + 4'd1 == LOCK_N) ? LOCKED : VERIFY;
            locked_d = (cnt_q + 4'd1 == LOCK_N);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SEARCH;
            px_en_q       <= 1'b0;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            vpend_q       <= 1'b0;
            hfirst_q      <= 1'b1;
            vfirst_q      <= 1'b1;
            hpos_q        <= MAX;
            vpos_q        <= MAX;
            cnt_q         <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            timing_err_q  <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            rgb_q         <= '0;
        end else begin
            state_q       <= state_d;
            px_en_q       <= px_en_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            vpend_q       <= vpend_d;
            hfirst_q      <= hfirst_d;
            vfirst_q      <= vfirst_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            cnt_q         <= cnt_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            timing_err_q  <= timing_err_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            rgb_q         <= rgb_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign PixX        = pix_x_q;
    assign PixY        = pix_y_q;
    assign RGB_out     = rgb_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign timing_err  = timing_err_q;
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: randomized self-checking bench for vga_capture on a scaled-down raster
module tb_vga_capture;
    localparam int HV = 8, HB = 3, HSW = 2, HT = 16;
    localparam int VV = 4, VB = 2, VSW = 1, VT = 9;
    localparam int LF = 2;
    localparam int HS0 = HSW + HB;
    localparam int VS0 = VSW + VB;

    logic        clk = 1'b0;
    logic        rst, Hsync, Vsync;
    logic [11:0] RGB_in;
    logic        pix_valid, frame_start, locked, timing_err;
    logic [9:0]  PixX, PixY;
    logic [11:0] RGB_out;

    vga_capture #(
        .H_VISIBLE(HV), .H_BACK(HB), .H_SYNC(HSW), .H_TOTAL(HT),
        .V_VISIBLE(VV), .V_BACK(VB), .V_SYNC(VSW), .V_TOTAL(VT), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .Hsync(Hsync), .Vsync(Vsync), .RGB_in(RGB_in),
        .pix_valid(pix_valid), .PixX(PixX), .PixY(PixY), .RGB_out(RGB_out),
        .frame_start(frame_start), .locked(locked), .timing_err(timing_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: one step per clock, expressed as sampled-input rules
    bit          cmp_en = 0;
    int          m_h, m_v, m_good;
    bit          m_px, m_hsp, m_vsp, m_vpend, m_hfirst, m_vfirst, m_locked;
    logic        e_pv, e_fs, e_err, e_lock;
    logic [9:0]  e_x, e_y;
    logic [11:0] e_rgb;

    task automatic model_step();
        bit hf, vf, bnd, lerr, ferr, tout;
        int nh, nv;
        if (rst) begin
            m_px = 0; m_hsp = 1; m_vsp = 1; m_vpend = 0; m_hfirst = 1; m_vfirst = 1;
            m_h = 1023; m_v = 1023; m_good = -1; m_locked = 0;
            e_pv = 0; e_fs = 0; e_err = 0; e_lock = 0; e_x = 0; e_y = 0; e_rgb = 0;
            cmp_en = 1;
            return;
        end
        e_pv = 0; e_fs = 0; e_err = 0;
        if (!m_px) begin
            m_px = 1;
            return;
        end
        m_px = 0;
        hf = !Hsync && m_hsp;
        vf = !Vsync && m_vsp;
        m_hsp = Hsync;
        m_vsp = Vsync;
        bnd = hf && (m_vpend || vf);
        nh = hf ? 0 : (m_h < 1023 ? m_h + 1 : 1023);
        nv = bnd ? 0 : (hf ? (m_v < 1023 ? m_v + 1 : 1023) : m_v);
        lerr = hf && !m_hfirst && (m_h != HT - 1);
        ferr = bnd && !m_vfirst && (m_v != VT - 1);
        tout = (nh == 1023) && (m_h != 1023);
        if (m_locked && nh >= HS0 && nh < HS0 + HV && nv >= VS0 && nv < VS0 + VV) begin
            e_pv = 1; e_x = 10'(nh - HS0); e_y = 10'(nv - VS0); e_rgb = RGB_in;
        end
        e_fs = bnd;
        e_err = lerr || ferr || tout;
        if (e_err) begin
            m_good = -1; m_locked = 0;
        end else if (bnd) begin
            m_good = (m_good < 0) ? 0 : m_good + 1;
            if (m_good >= LF) m_locked = 1;
        end
        e_lock = m_locked;
        m_h = nh;
        m_v = nv;
        m_vpend = bnd ? 0 : (m_vpend || vf);
        m_hfirst = tout || (m_hfirst && !hf);
        m_vfirst = tout || (m_vfirst && !bnd);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // per-cycle compare plus observation statistics of the DUT
    int          fs_n = 0, pv_cnt = 0, pv_total = 0, err_n = 0, pv_mark = 0;
    logic        lock_fs [64];
    logic [31:0] hist_pv [64], hist_first [64], hist_last [64];
    logic [31:0] cur_first = 0, cur_last = 0;
    bit          pattern = 1;

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("pix_valid", pix_valid, e_pv);
            chk("PixX", PixX, e_x);
            chk("PixY", PixY, e_y);
            chk("RGB_out", RGB_out, e_rgb);
            chk("frame_start", frame_start, e_fs);
            chk("locked", locked, e_lock);
            chk("timing_err", timing_err, e_err);
        end
        if (timing_err === 1'b1) err_n++;
        if (frame_start === 1'b1) begin
            if (fs_n < 63) begin
                hist_pv[fs_n] = pv_cnt; hist_first[fs_n] = cur_first; hist_last[fs_n] = cur_last;
                fs_n++;
                lock_fs[fs_n] = locked;
            end
            pv_cnt = 0;
        end
        if (pix_valid === 1'b1) begin
            if (pv_cnt == 0) cur_first = {PixX, PixY, RGB_out};
            cur_last = {PixX, PixY, RGB_out};
            pv_cnt++;
            pv_total++;
            if (pattern) chk("loopback_rgb", RGB_out, {PixX[3:0], PixY[3:0], 4'hA});
        end
    end

    // reference timing generator: one pixel per two clocks, entered and left on a negedge
    task automatic drive_pixel(input int p, input int l, input bit do_rst);
        logic [9:0] xv, yv;
        xv = 10'(p - HS0);
        yv = 10'(l - VS0);
        Hsync = (p >= HSW);
        Vsync = (l >= VSW);
        RGB_in = (pattern && p >= HS0 && p < HS0 + HV && l >= VS0 && l < VS0 + VV) ?
                 {xv[3:0], yv[3:0], 4'hA} : 12'($urandom);
        if (do_rst) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            pv_mark = pv_total;
            @(negedge clk);
        end else begin
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic drive_frame(input int short_line, input int rst_line, input int rst_pix);
        for (int l = 0; l < VT; l++)
            for (int p = 0; p < ((l == short_line) ? HT - 1 : HT); p++)
                drive_pixel(p, l, (l == rst_line) && (p == rst_pix));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0, n, rl, rp;
        rst = 1'b1; Hsync = 1'b1; Vsync = 1'b1; RGB_in = '0;
        repeat (4) begin
            @(negedge clk);
            Hsync = 1'($urandom); Vsync = 1'($urandom); RGB_in = 12'($urandom);
        end
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_timing_err", timing_err, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_pix", {PixX, PixY, RGB_out}, 0);
        rst = 1'b0;
        repeat (4) drive_frame(-1, -1, -1);
        chk("fs_count", fs_n, 4);
        chk("lock_at_fs1", lock_fs[1], 0);
        chk("lock_at_fs2", lock_fs[2], 0);
        chk("lock_at_fs3", lock_fs[3], 1);
        chk("frame3_strobes", hist_pv[3], 32);
        chk("frame3_first", hist_first[3], {10'd0, 10'd0, 12'h00A});
        chk("frame3_last", hist_last[3], {10'd7, 10'd3, 12'h73A});

        e0 = err_n;
        drive_frame(5, -1, -1);
        chk("short_line_err", err_n - e0, 1);
        chk("short_line_unlock", locked, 0);
        pattern = 1'($urandom);
        repeat (2) drive_frame(-1, -1, -1);
        chk("short_relock_fs_a", lock_fs[fs_n - 1], 0);
        chk("short_relock_fs_b", lock_fs[fs_n], 0);
        pattern = 1;
        drive_frame(-1, -1, -1);
        chk("short_relock", lock_fs[fs_n], 1);
        chk("short_relock_level", locked, 1);

        e0 = err_n;
        n = 1100 + int'($urandom_range(0, 200));
        Hsync = 1'b1; Vsync = 1'b1;
        repeat (n) begin
            RGB_in = 12'($urandom);
            repeat (2) @(negedge clk);
        end
        chk("timeout_err_once", err_n - e0, 1);
        chk("timeout_unlock", locked, 0);
        repeat (3) drive_frame(-1, -1, -1);
        chk("timeout_relock_prev", lock_fs[fs_n - 1], 0);
        chk("timeout_relock", lock_fs[fs_n], 1);

        rl = int'($urandom_range(VS0, VS0 + VV - 1));
        rp = int'($urandom_range(HS0, HS0 + HV - 1));
        drive_frame(-1, rl, rp);
        repeat (2) drive_frame(-1, -1, -1);
        chk("rst_mid_no_strobe", pv_total - pv_mark, 0);
        chk("rst_mid_unlocked", locked, 0);
        drive_frame(-1, -1, -1);
        chk("rst_mid_relock", locked, 1);
        chk("rst_mid_strobes", pv_total - pv_mark, 32);

        repeat (2) begin
            pattern = 1'($urandom);
            drive_frame(-1, -1, -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
